// File: rtl/gin_pkg.sv
// Shared GIN bus definitions: field widths, packed-word offsets and pack/unpack helpers.
package gin_pkg;
  localparam int ID_LEN    = 5;
  localparam int VALUE_LEN = 32;
  localparam int EN_BIT    = VALUE_LEN + ID_LEN;
  localparam int TAG_MSB   = EN_BIT - 1;
  localparam int TAG_LSB   = VALUE_LEN;

  typedef struct packed {
    logic                 enable;
    logic [ID_LEN-1:0]    tag;
    logic [VALUE_LEN-1:0] value;
  } gin_word_t;

  function automatic logic [EN_BIT:0] gin_pack(input logic enable,
                                               input logic [ID_LEN-1:0] tag,
                                               input logic [VALUE_LEN-1:0] value);
    return {enable, tag, value};
  endfunction

  function automatic gin_word_t gin_unpack(input logic [EN_BIT:0] word);
    return gin_word_t'(word);
  endfunction
endpackage

// File: rtl/gin_sync_fifo.sv
// Single-clock FIFO with occupancy count, synchronous clear and combinational head read.
module gin_sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage is never reset; reads are masked by empty at the consumer.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/gin_packet_feeder.sv
// GIN row-bus source: queues tagged packets and presents the head as {enable, tag, value}.
module gin_packet_feeder #(
  parameter int ID_LEN    = gin_pkg::ID_LEN,
  parameter int VALUE_LEN = gin_pkg::VALUE_LEN,
  parameter int DEPTH     = 4,
  parameter int CNT_LEN   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ID_LEN-1:0]            in_tag,
  input  logic [VALUE_LEN-1:0]         in_value,
  input  logic                         bus_ready,
  output logic [VALUE_LEN+ID_LEN:0]    bus_enable_tag_value,
  output logic [$clog2(DEPTH):0]       level,
  output logic [CNT_LEN-1:0]           sent_cnt,
  output logic [CNT_LEN-1:0]           stall_cnt
);
  localparam int PW = ID_LEN + VALUE_LEN;

  logic          full, empty, push, pop, enable;
  logic [PW-1:0] head;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign enable   = !empty;
  assign pop      = enable && bus_ready;

  // Whole word is zero when idle so downstream never sees a stale tag.
  assign bus_enable_tag_value = enable ? {1'b1, head} : '0;

  gin_sync_fifo #(.WIDTH(PW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata ({in_tag, in_value}),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_cnt  <= '0;
      stall_cnt <= '0;
    end else if (clear) begin
      sent_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop)                   sent_cnt  <= sent_cnt + 1'b1;
      if (enable && !bus_ready)  stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule
